// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle main control FSM and its output decoder.
// The ALUOp codes are also consumed by the ALU control decoder, so keep them here.
package multicycle_control_pkg;

  localparam int OPW = 4;
  localparam int STW = 4;

  // Opcodes (IR[15:12])
  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_LW    = 4'b1000;
  localparam logic [3:0] OP_SW    = 4'b1011;
  localparam logic [3:0] OP_BEQ   = 4'b0100;
  localparam logic [3:0] OP_JMP   = 4'b0010;
  localparam logic [3:0] OP_ADDI  = 4'b1100;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  // ALUOp codes handed to the ALU control decoder
  localparam logic [1:0] ALUOP_RTYPE = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_ADD   = 2'b10;

  // ALU B input select
  localparam logic [1:0] SRCB_REGB  = 2'b00;
  localparam logic [1:0] SRCB_ONE   = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_BROFF = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // State encodings; 14 and 15 are unused and recover to IDLE
  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_RWB    = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_ADDIEX = 4'd11,
    S_ADDIWB = 4'd12,
    S_HALT   = 4'd13
  } state_e;

  // Full datapath control word
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
    logic       halted;
  } ctrl_t;

  // True for every opcode the datapath implements
  function automatic logic is_legal_op(input logic [3:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) ||
           (op == OP_JMP) || (op == OP_ADDI) || (op == OP_HALT);
  endfunction

endpackage

// File: rtl/multicycle_control_outdec.sv
// Purely combinational decode of the current state (plus MemReady in FETCH)
// into the datapath control word.
module multicycle_control_outdec
  import multicycle_control_pkg::*;
(
  input  state_e state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  // Moore decode per state; the instruction load in FETCH follows MemReady
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_ONE;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_BROFF;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REGB;
        ctrl.alu_op    = ALUOP_RTYPE;
      end
      S_RWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_REGB;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      S_ADDIWB: begin
        ctrl.reg_write = 1'b1;
      end
      S_HALT: begin
        ctrl.halted = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle datapath: state register, next-state
// logic and the sticky illegal-opcode flag. Outputs come from the decoder.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int OPW = multicycle_control_pkg::OPW,
  parameter int STW = multicycle_control_pkg::STW
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [OPW-1:0] Opcode,
  input  logic           MemReady,
  output logic           PCWrite,
  output logic           PCWriteCond,
  output logic           IorD,
  output logic           MemRead,
  output logic           MemWrite,
  output logic           IRWrite,
  output logic           MemtoReg,
  output logic           RegDst,
  output logic           RegWrite,
  output logic           ALUSrcA,
  output logic [1:0]     ALUSrcB,
  output logic [1:0]     PCSource,
  output logic [1:0]     ALUOp,
  output logic           Halted,
  output logic           Illegal,
  output logic [STW-1:0] State
);

  state_e state_reg, state_next;
  logic   illegal_reg, illegal_next;
  // Remembers LW vs SW from DECODE so MEMADR never looks at Opcode again
  logic   is_load_reg, is_load_next;
  ctrl_t  ctrl;

  // State and flag registers, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= S_IDLE;
      illegal_reg <= 1'b0;
      is_load_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      illegal_reg <= illegal_next;
      is_load_reg <= is_load_next;
    end
  end

  // Next-state logic; Opcode is only consulted in DECODE
  always_comb begin
    state_next   = state_reg;
    illegal_next = illegal_reg;
    is_load_next = is_load_reg;
    case (state_reg)
      S_IDLE:   state_next = S_FETCH;
      S_FETCH:  state_next = MemReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        is_load_next = (Opcode == OP_LW);
        case (Opcode)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_EXEC;
          OP_BEQ:       state_next = S_BRANCH;
          OP_JMP:       state_next = S_JUMP;
          OP_ADDI:      state_next = S_ADDIEX;
          default:      state_next = S_HALT;
        endcase
        if (!is_legal_op(Opcode)) begin
          illegal_next = 1'b1;
        end
      end
      S_MEMADR: state_next = is_load_reg ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_next = MemReady ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_next = S_FETCH;
      S_MEMWR:  state_next = MemReady ? S_FETCH : S_MEMWR;
      S_EXEC:   state_next = S_RWB;
      S_RWB:    state_next = S_FETCH;
      S_BRANCH: state_next = S_FETCH;
      S_JUMP:   state_next = S_FETCH;
      S_ADDIEX: state_next = S_ADDIWB;
      S_ADDIWB: state_next = S_FETCH;
      S_HALT:   state_next = S_HALT;
      default:  state_next = S_IDLE;
    endcase
  end

  multicycle_control_outdec u_outdec (
    .state     (state_reg),
    .mem_ready (MemReady),
    .ctrl      (ctrl)
  );

  assign PCWrite     = ctrl.pc_write;
  assign PCWriteCond = ctrl.pc_write_cond;
  assign IorD        = ctrl.iord;
  assign MemRead     = ctrl.mem_read;
  assign MemWrite    = ctrl.mem_write;
  assign IRWrite     = ctrl.ir_write;
  assign MemtoReg    = ctrl.mem_to_reg;
  assign RegDst      = ctrl.reg_dst;
  assign RegWrite    = ctrl.reg_write;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign PCSource    = ctrl.pc_source;
  assign ALUOp       = ctrl.alu_op;
  assign Halted      = ctrl.halted;
  assign Illegal     = illegal_reg;
  assign State       = STW'(state_reg);

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: instructions are expanded into the expected
// per-cycle state path, and a compare process checks every cycle's outputs.
module tb_multicycle_control;
  import multicycle_control_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] Opcode = 4'b0;
  logic       MemReady = 1'b0;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, Halted, Illegal;
  logic [1:0] ALUSrcB, PCSource, ALUOp;
  logic [3:0] State;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .MemReady(MemReady),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .ALUOp(ALUOp), .Halted(Halted), .Illegal(Illegal), .State(State)
  );

  typedef struct packed {
    state_e st;
    logic   rdy;
    logic   ill;
  } exp_t;

  exp_t        q[$];
  exp_t        cur;
  int          errors = 0;
  int          checks = 0;
  logic        ill_m = 1'b0;
  logic [21:0] exp_w;
  logic [21:0] act_w;
  int          len;

  assign act_w = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                  RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUOp, Halted,
                  Illegal, State};

  // Expected control word straight from the per-state output table
  function automatic logic [21:0] model_word(input state_e st, input logic rdy, input logic ill);
    logic pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, sa, hlt;
    logic [1:0] sb, ps, op;
    {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, sa, hlt} = '0;
    sb = 2'b00; ps = 2'b00; op = 2'b00;
    case (st)
      S_FETCH:  begin mr = 1; sb = 2'b01; op = 2'b10; irw = rdy; pcw = rdy; end
      S_DECODE: begin sb = 2'b11; op = 2'b10; end
      S_MEMADR: begin sa = 1; sb = 2'b10; op = 2'b10; end
      S_MEMRD:  begin mr = 1; iord = 1; end
      S_MEMWB:  begin rw = 1; m2r = 1; end
      S_MEMWR:  begin mw = 1; iord = 1; end
      S_EXEC:   begin sa = 1; end
      S_RWB:    begin rw = 1; rd = 1; end
      S_BRANCH: begin sa = 1; op = 2'b01; pcwc = 1; ps = 2'b01; end
      S_JUMP:   begin pcw = 1; ps = 2'b10; end
      S_ADDIEX: begin sa = 1; sb = 2'b10; op = 2'b10; end
      S_ADDIWB: begin rw = 1; end
      S_HALT:   begin hlt = 1; end
      default:  ;
    endcase
    return {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, sa, sb, ps, op, hlt, ill, 4'(st)};
  endfunction

  // Per-cycle comparison against the queued expectation
  always @(negedge clk) begin
    if (q.size() > 0) begin
      cur = q.pop_front();
      exp_w = model_word(cur.st, cur.rdy, cur.ill);
      checks++;
      if (act_w !== exp_w) begin
        errors++;
        $display("FAIL cycle_word t=%0t state act=%0d req=%0d word act=%h req=%h",
                 $time, State, cur.st, act_w, exp_w);
      end
      checks++;
      if (MemRead && MemWrite) begin
        errors++;
        $display("FAIL mem_exclusive t=%0t MemRead=%b MemWrite=%b req not both", $time, MemRead, MemWrite);
      end
      checks++;
      if (PCWrite && PCWriteCond) begin
        errors++;
        $display("FAIL pc_exclusive t=%0t PCWrite=%b PCWriteCond=%b req not both", $time, PCWrite, PCWriteCond);
      end
    end
  end

  function automatic logic [3:0] rnd_op();
    return 4'($urandom_range(0, 15));
  endfunction

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  // One clock cycle: drive inputs, queue what this cycle must look like
  task automatic cyc(input state_e st, input logic rdy, input logic [3:0] op);
    MemReady = rdy;
    Opcode = op;
    q.push_back('{st: st, rdy: rdy, ill: ill_m});
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s act=%0d req=%0d", name, act, req);
    end
  endtask

  // Reset asserted asynchronously, held two edges, released, ending in FETCH
  task automatic do_reset();
    reset = 1'b1;
    ill_m = 1'b0;
    #2;
    check_val("reset_async_word", int'(act_w), 0);
    cyc(S_IDLE, rnd_bit(), rnd_op());
    cyc(S_IDLE, rnd_bit(), rnd_op());
    reset = 1'b0;
    cyc(S_IDLE, rnd_bit(), rnd_op());
  endtask

  // Expand one instruction into its expected cycle-by-cycle state path
  task automatic run_instr(input logic [3:0] op, input int fw, input int mw, output int n);
    n = 0;
    for (int i = 0; i < fw; i++) begin cyc(S_FETCH, 1'b0, rnd_op()); n++; end
    cyc(S_FETCH, 1'b1, rnd_op()); n++;
    cyc(S_DECODE, rnd_bit(), op); n++;
    case (op)
      4'b0000: begin cyc(S_EXEC, rnd_bit(), rnd_op()); cyc(S_RWB, rnd_bit(), rnd_op()); n += 2; end
      4'b1000: begin
        cyc(S_MEMADR, rnd_bit(), rnd_op()); n++;
        for (int i = 0; i < mw; i++) begin cyc(S_MEMRD, 1'b0, rnd_op()); n++; end
        cyc(S_MEMRD, 1'b1, rnd_op()); cyc(S_MEMWB, rnd_bit(), rnd_op()); n += 2;
      end
      4'b1011: begin
        cyc(S_MEMADR, rnd_bit(), rnd_op()); n++;
        for (int i = 0; i < mw; i++) begin cyc(S_MEMWR, 1'b0, rnd_op()); n++; end
        cyc(S_MEMWR, 1'b1, rnd_op()); n++;
      end
      4'b0100: begin cyc(S_BRANCH, rnd_bit(), rnd_op()); n++; end
      4'b0010: begin cyc(S_JUMP, rnd_bit(), rnd_op()); n++; end
      4'b1100: begin cyc(S_ADDIEX, rnd_bit(), rnd_op()); cyc(S_ADDIWB, rnd_bit(), rnd_op()); n += 2; end
      default: begin
        if (op != 4'b1111) ill_m = 1'b1;
        cyc(S_HALT, rnd_bit(), rnd_op()); n++;
      end
    endcase
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk);
    #1;
    do_reset();

    // Reset in the middle of a load that is waiting on memory
    cyc(S_FETCH, 1'b1, rnd_op());
    cyc(S_DECODE, 1'b0, 4'b1000);
    cyc(S_MEMADR, 1'b1, rnd_op());
    cyc(S_MEMRD, 1'b0, rnd_op());
    cyc(S_MEMRD, 1'b0, rnd_op());
    do_reset();
    check_val("post_reset_state", int'(State), int'(S_FETCH));
    check_val("post_reset_memread", int'(MemRead), 1);
    check_val("post_reset_aluop", int'(ALUOp), 2);
    check_val("post_reset_illegal", int'(Illegal), 0);

    run_instr(4'b0000, 0, 0, len); check_val("len_rtype", len, 4);
    run_instr(4'b1000, 0, 3, len); check_val("len_lw_wait3", len, 8);
    run_instr(4'b1011, 0, 0, len); check_val("len_sw", len, 4);
    run_instr(4'b0100, 0, 0, len); check_val("len_beq", len, 3);
    run_instr(4'b0010, 2, 0, len); check_val("len_jmp_fetchwait2", len, 5);
    run_instr(4'b1100, 0, 0, len); check_val("len_addi", len, 4);
    run_instr(4'b1000, 0, 0, len); check_val("len_lw", len, 5);
    run_instr(4'b1011, 1, 2, len); check_val("len_sw_waits", len, 7);

    // Illegal opcode parks the FSM in HALT
    run_instr(4'b0111, 0, 0, len);
    for (int i = 0; i < 20; i++) cyc(S_HALT, rnd_bit(), rnd_op());
    check_val("halt_halted", int'(Halted), 1);
    check_val("halt_illegal", int'(Illegal), 1);
    do_reset();
    check_val("after_halt_illegal", int'(Illegal), 0);

    // Legal HALT opcode: halted but not flagged illegal
    run_instr(4'b1111, 0, 0, len);
    for (int i = 0; i < 5; i++) cyc(S_HALT, rnd_bit(), rnd_op());
    check_val("halt_legal_illegal", int'(Illegal), 0);
    do_reset();
    run_instr(4'b0000, 0, 0, len); check_val("len_rtype_after_halt", len, 4);

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
